// File: rtl/pipeline_stage_register_pkg.sv
// Shared types for the inter-stage pipeline registers: payload layouts,
// bubble encodings and the skid-buffer control states.
package pipeline_stage_register_pkg;

  localparam int unsigned DATA_BUS = 32;
  localparam logic [DATA_BUS-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [DATA_BUS-1:0] instr;
    logic [DATA_BUS-1:0] pc;
    logic [DATA_BUS-1:0] pc_plus4;
  } fd_payload_t;

  localparam int unsigned FD_WIDTH = $bits(fd_payload_t);
  localparam fd_payload_t FD_BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipeline_stage_register.sv
// Valid/ready pipeline register with a two-entry skid buffer and a flush
// that drops all held entries and presents the bubble payload.
module pipeline_stage_register
  import pipeline_stage_register_pkg::*;
#(
  parameter int unsigned        WIDTH   = FD_WIDTH,
  parameter logic [WIDTH-1:0]   BUBBLE  = '0,
  parameter bit                 NEGEDGE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occupancy_o
);

  skid_state_e      r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [1:0]       r_occupancy;

  skid_state_e      w_state_nxt;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_push;
  logic             w_pop;

  assign w_push = in_valid_i & r_in_ready;
  assign w_pop  = r_out_valid & out_ready_i;

  // Next-state: flush wins over every handshake; main reverts to BUBBLE whenever it empties.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = BUBBLE;
      w_skid_nxt  = BUBBLE;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = in_data_i;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            w_main_nxt = in_data_i;
          end else if (w_push) begin
            w_state_nxt = ST_TWO;
            w_skid_nxt  = in_data_i;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = BUBBLE;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
            w_skid_nxt  = BUBBLE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = BUBBLE;
          w_skid_nxt  = BUBBLE;
        end
      endcase
    end
  end

  // Status flags are registered straight from the next state so no output has a comb path.
  generate
    if (NEGEDGE) begin : g_neg
      always_ff @(negedge clk) begin
        if (!rst_n) begin
          r_state     <= ST_EMPTY;
          r_main      <= BUBBLE;
          r_skid      <= BUBBLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_occupancy <= 2'd0;
        end else begin
          r_state     <= w_state_nxt;
          r_main      <= w_main_nxt;
          r_skid      <= w_skid_nxt;
          r_in_ready  <= (w_state_nxt != ST_TWO);
          r_out_valid <= (w_state_nxt != ST_EMPTY);
          r_occupancy <= 2'(w_state_nxt);
        end
      end
    end else begin : g_pos
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_state     <= ST_EMPTY;
          r_main      <= BUBBLE;
          r_skid      <= BUBBLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_occupancy <= 2'd0;
        end else begin
          r_state     <= w_state_nxt;
          r_main      <= w_main_nxt;
          r_skid      <= w_skid_nxt;
          r_in_ready  <= (w_state_nxt != ST_TWO);
          r_out_valid <= (w_state_nxt != ST_EMPTY);
          r_occupancy <= 2'(w_state_nxt);
        end
      end
    end
  endgenerate

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_main;
  assign occupancy_o = r_occupancy;

endmodule
